// File: rtl/alu_pkg.sv
// Opcode definitions shared by the 4-bit ALU and its command queue.
package alu_pkg;
  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    AND = 3'd3,
    DEC = 3'd4
  } alu_opcode_t;
endpackage

// File: rtl/alu_cmd_queue_if.sv
// Command-in, ALU-side and result-out signal bundle of the ALU command queue.
// The queue connects through the slave modport; the producer/ALU/consumer side uses master.
interface alu_cmd_queue_if #(
  parameter int N     = 8,
  parameter int TAG_W = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_a;
  logic [3:0]            in_b;
  alu_pkg::alu_opcode_t  in_op;

  logic [3:0]            alu_a;
  logic [3:0]            alu_b;
  alu_pkg::alu_opcode_t  alu_op;
  logic [N-1:0]          alu_result;

  logic                  out_valid;
  logic                  out_ready;
  logic [N-1:0]          out_result;
  alu_pkg::alu_opcode_t  out_op;
  logic [TAG_W-1:0]      out_tag;
  logic                  out_err;

  modport master (
    output in_valid, in_a, in_b, in_op,
    input  in_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result,
    input  out_valid, out_result, out_op, out_tag, out_err,
    output out_ready
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op,
    output in_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result,
    output out_valid, out_result, out_op, out_tag, out_err,
    input  out_ready
  );
endinterface

// File: rtl/alu_cmd_queue.sv
// DEPTH-entry command FIFO feeding the ALU, with a registered tagged result slot.
// Head-to-result one cycle; in_ready from occupancy only; result slot holds while out_ready is low.
module alu_cmd_queue
  import alu_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_cmd_queue_if.slave         bus,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [3:0]  a;
    logic [3:0]  b;
    alu_opcode_t op;
  } cmd_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [TAG_W-1:0] tag_cnt;
  logic             push;
  logic             pop;
  logic             op_bad;

  assign bus.in_ready = (count < FULL_CNT);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (count != '0) && (!bus.out_valid || bus.out_ready);

  // Head is presented even when empty; the ALU output is ignored then.
  assign head       = mem[rd_ptr];
  assign bus.alu_a  = head.a;
  assign bus.alu_b  = head.b;
  assign bus.alu_op = head.op;

  always_comb begin
    op_bad = 1'b0;
    case (head.op)
      ADD, SUB, MUL, AND, DEC: op_bad = 1'b0;
      default:                 op_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: bus.in_a, b: bus.in_b, op: bus.in_op};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        tag_cnt <= tag_cnt + TAG_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A pop refills the slot in the same edge it drains, giving one result per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_op     <= ADD;
      bus.out_tag    <= '0;
      bus.out_err    <= 1'b0;
    end else if (pop) begin
      bus.out_valid  <= 1'b1;
      bus.out_result <= bus.alu_result;
      bus.out_op     <= head.op;
      bus.out_tag    <= tag_cnt;
      bus.out_err    <= op_bad;
    end else if (bus.out_ready) begin
      bus.out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed bench for alu_cmd_queue with a behavioural 4-bit ALU and a result scoreboard.
module tb_alu_cmd_queue;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [2:0] count;

  int tests = 0;
  int fails = 0;

  alu_cmd_queue_if #(.N(8), .TAG_W(4)) bus ();

  alu_cmd_queue #(.N(8), .DEPTH(4), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .count (count)
  );

  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input alu_opcode_t op);
    case (op)
      ADD:     return {4'b0, a} + {4'b0, b};
      SUB:     return {4'b0, a} - {4'b0, b};
      MUL:     return {4'b0, a} * {4'b0, b};
      AND:     return {4'b0, a & b};
      DEC:     return 8'd1 << a;
      default: return 8'd0;
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  res;
    alu_opcode_t op;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        e;
  logic [3:0]  a_v;
  logic [3:0]  b_v;
  alu_opcode_t op_v;
  logic [3:0]  model_tag;
  logic [3:0]  last_tag;
  logic        wrapped;
  int          sent;
  int          got;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input alu_opcode_t op);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 4'd0, 4'd0, ADD);
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    do_reset();

    // Reset state
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_tag", 32'(bus.out_tag), 32'd0);
    check("rst_out_op", 32'(bus.out_op), 32'(ADD));
    check("rst_out_result", 32'(bus.out_result), 32'd0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);

    // Single ADD: pushed at T, result registered at T+1
    bus.out_ready = 1'b1;
    drive(1'b1, 4'd3, 4'd5, ADD);
    step();
    drive(1'b0, 4'd0, 4'd0, ADD);
    check("t1_count", 32'(count), 32'd1);
    check("t1_head_a", 32'(bus.alu_a), 32'd3);
    check("t1_early_valid", 32'(bus.out_valid), 32'd0);
    step();
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_result", 32'(bus.out_result), 32'h08);
    check("t1_tag", 32'(bus.out_tag), 32'd0);
    check("t1_err", 32'(bus.out_err), 32'd0);
    step();
    check("t1_drain", 32'(bus.out_valid), 32'd0);

    // Back-to-back MUL, SUB, AND, DEC at full throughput
    do_reset();
    bus.out_ready = 1'b1;
    drive(1'b1, 4'hF, 4'hF, MUL);
    step();
    check("t2_valid0", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 4'd7, 4'd2, SUB);
    step();
    check("t2_mul_res", 32'(bus.out_result), 32'hE1);
    check("t2_mul_tag", 32'(bus.out_tag), 32'd0);
    drive(1'b1, 4'hC, 4'hA, AND);
    step();
    check("t2_sub_res", 32'(bus.out_result), 32'h05);
    check("t2_sub_tag", 32'(bus.out_tag), 32'd1);
    drive(1'b1, 4'd2, 4'd0, DEC);
    step();
    check("t2_and_res", 32'(bus.out_result), 32'h08);
    check("t2_and_tag", 32'(bus.out_tag), 32'd2);
    drive(1'b0, 4'd0, 4'd0, ADD);
    step();
    check("t2_dec_res", 32'(bus.out_result), 32'h04);
    check("t2_dec_tag", 32'(bus.out_tag), 32'd3);
    check("t2_dec_op", 32'(bus.out_op), 32'(DEC));
    check("t2_dec_valid", 32'(bus.out_valid), 32'd1);
    step();
    check("t2_drain", 32'(bus.out_valid), 32'd0);

    // Stalled consumer: slot takes one, FIFO takes four, sixth is refused
    do_reset();
    drive(1'b1, 4'd1, 4'd1, ADD);
    step();
    check("t3_count_a", 32'(count), 32'd1);
    drive(1'b1, 4'd2, 4'd2, ADD);
    step();
    check("t3_count_b", 32'(count), 32'd1);
    check("t3_valid", 32'(bus.out_valid), 32'd1);
    check("t3_res_b", 32'(bus.out_result), 32'h02);
    drive(1'b1, 4'd9, 4'd4, SUB);
    step();
    check("t3_count_c", 32'(count), 32'd2);
    drive(1'b1, 4'd3, 4'd3, MUL);
    step();
    check("t3_count_d", 32'(count), 32'd3);
    drive(1'b1, 4'hF, 4'd3, AND);
    step();
    check("t3_count_full", 32'(count), 32'd4);
    check("t3_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 4'd7, 4'd7, ADD);
    for (int i = 0; i < 2; i++) begin
      step();
      check("t3_hold_count", 32'(count), 32'd4);
      check("t3_hold_ready", 32'(bus.in_ready), 32'd0);
      check("t3_hold_res", 32'(bus.out_result), 32'h02);
      check("t3_hold_tag", 32'(bus.out_tag), 32'd0);
    end

    // One-cycle out_ready pulse from full with the refused command still offered
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("t4_count_pop", 32'(count), 32'd3);
    check("t4_res1", 32'(bus.out_result), 32'h04);
    check("t4_tag1", 32'(bus.out_tag), 32'd1);
    step();
    drive(1'b0, 4'd0, 4'd0, ADD);
    check("t4_count_refill", 32'(count), 32'd4);
    check("t4_res1_hold", 32'(bus.out_result), 32'h04);
    bus.out_ready = 1'b1;
    step();
    check("t4_res2", 32'(bus.out_result), 32'h05);
    check("t4_tag2", 32'(bus.out_tag), 32'd2);
    step();
    check("t4_res3", 32'(bus.out_result), 32'h09);
    check("t4_tag3", 32'(bus.out_tag), 32'd3);
    step();
    check("t4_res4", 32'(bus.out_result), 32'h03);
    check("t4_tag4", 32'(bus.out_tag), 32'd4);
    step();
    check("t4_res5", 32'(bus.out_result), 32'h0E);
    check("t4_tag5", 32'(bus.out_tag), 32'd5);
    check("t4_count_empty", 32'(count), 32'd0);
    step();
    check("t4_drain", 32'(bus.out_valid), 32'd0);

    // Twenty commands with irregular consumer stalls, tag wrap and one invalid opcode
    do_reset();
    sent      = 0;
    got       = 0;
    model_tag = 4'd0;
    last_tag  = 4'd0;
    wrapped   = 1'b0;
    for (int cyc = 0; cyc < 300 && got < 20; cyc++) begin
      a_v  = 4'(sent * 3 + 1);
      b_v  = 4'(sent * 5 + 2);
      op_v = (sent == 7) ? alu_opcode_t'(3'd6) : alu_opcode_t'(3'(sent % 5));
      drive(sent < 20, a_v, b_v, op_v);
      bus.out_ready = (cyc % 4 != 3);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", 32'(bus.out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_result", 32'(bus.out_result), 32'(e.res));
          check("sb_op", 32'(bus.out_op), 32'(e.op));
          check("sb_tag", 32'(bus.out_tag), 32'(e.tag));
          check("sb_err", 32'(bus.out_err), 32'(e.err));
          if (got > 0 && last_tag == 4'd15 && bus.out_tag == 4'd0) wrapped = 1'b1;
          last_tag = bus.out_tag;
          got++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back('{res: alu_f(a_v, b_v, op_v), op: op_v, tag: model_tag,
                          err: (3'(op_v) > 3'd4)});
        model_tag = model_tag + 4'd1;
        sent++;
      end
      step();
    end
    drive(1'b0, 4'd0, 4'd0, ADD);
    check("sb_received", 32'(got), 32'd20);
    check("sb_tag_wrap", 32'(wrapped), 32'd1);
    check("sb_count_empty", 32'(count), 32'd0);

    // Asynchronous reset with three queued and one result pending
    do_reset();
    drive(1'b1, 4'd1, 4'd1, ADD);
    step();
    drive(1'b1, 4'd2, 4'd1, ADD);
    step();
    drive(1'b1, 4'd3, 4'd1, ADD);
    step();
    drive(1'b1, 4'd4, 4'd1, ADD);
    step();
    drive(1'b0, 4'd0, 4'd0, ADD);
    check("t6_pre_count", 32'(count), 32'd3);
    check("t6_pre_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_tag", 32'(bus.out_tag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 4'd6, 4'd7, ADD);
    step();
    drive(1'b0, 4'd0, 4'd0, ADD);
    check("t6_post_count", 32'(count), 32'd1);
    step();
    check("t6_post_valid", 32'(bus.out_valid), 32'd1);
    check("t6_post_res", 32'(bus.out_result), 32'h0D);
    check("t6_post_tag", 32'(bus.out_tag), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
